// File: rtl/exec_unit.sv
// exec_unit: registered integer execution unit between an RS issue port and the CDB.
// Single-cycle RV32I ALU/jump/branch ops, iterative shift-add RV32M multiplies,
// result held until granted, everything in flight dropped on flush.
module exec_unit #(
    parameter int XLEN      = 32,
    parameter int ROB_WIDTH = 4,
    parameter int OP_WIDTH  = 6
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 flush,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [OP_WIDTH-1:0]  in_op,
    input  logic [XLEN-1:0]      in_a,
    input  logic [XLEN-1:0]      in_b,
    input  logic [XLEN-1:0]      in_imm,
    input  logic [XLEN-1:0]      in_pc,
    input  logic [ROB_WIDTH-1:0] in_tag,
    output logic                 out_valid,
    input  logic                 out_grant,
    output logic [XLEN-1:0]      out_data,
    output logic [ROB_WIDTH-1:0] out_tag,
    output logic                 out_jump,
    output logic [XLEN-1:0]      out_jump_addr
);

    localparam int SHW = $clog2(XLEN);
    localparam int CW  = $clog2(XLEN) + 1;

    localparam logic [OP_WIDTH-1:0] OP_ADD    = OP_WIDTH'(1);
    localparam logic [OP_WIDTH-1:0] OP_SUB    = OP_WIDTH'(2);
    localparam logic [OP_WIDTH-1:0] OP_AND    = OP_WIDTH'(3);
    localparam logic [OP_WIDTH-1:0] OP_OR     = OP_WIDTH'(4);
    localparam logic [OP_WIDTH-1:0] OP_XOR    = OP_WIDTH'(5);
    localparam logic [OP_WIDTH-1:0] OP_ADDI   = OP_WIDTH'(6);
    localparam logic [OP_WIDTH-1:0] OP_ANDI   = OP_WIDTH'(7);
    localparam logic [OP_WIDTH-1:0] OP_ORI    = OP_WIDTH'(8);
    localparam logic [OP_WIDTH-1:0] OP_XORI   = OP_WIDTH'(9);
    localparam logic [OP_WIDTH-1:0] OP_SLL    = OP_WIDTH'(10);
    localparam logic [OP_WIDTH-1:0] OP_SRL    = OP_WIDTH'(11);
    localparam logic [OP_WIDTH-1:0] OP_SRA    = OP_WIDTH'(12);
    localparam logic [OP_WIDTH-1:0] OP_SLLI   = OP_WIDTH'(13);
    localparam logic [OP_WIDTH-1:0] OP_SRLI   = OP_WIDTH'(14);
    localparam logic [OP_WIDTH-1:0] OP_SRAI   = OP_WIDTH'(15);
    localparam logic [OP_WIDTH-1:0] OP_SLT    = OP_WIDTH'(16);
    localparam logic [OP_WIDTH-1:0] OP_SLTI   = OP_WIDTH'(17);
    localparam logic [OP_WIDTH-1:0] OP_SLTU   = OP_WIDTH'(18);
    localparam logic [OP_WIDTH-1:0] OP_SLTIU  = OP_WIDTH'(19);
    localparam logic [OP_WIDTH-1:0] OP_LUI    = OP_WIDTH'(20);
    localparam logic [OP_WIDTH-1:0] OP_AUIPC  = OP_WIDTH'(21);
    localparam logic [OP_WIDTH-1:0] OP_JAL    = OP_WIDTH'(22);
    localparam logic [OP_WIDTH-1:0] OP_JALR   = OP_WIDTH'(23);
    localparam logic [OP_WIDTH-1:0] OP_BEQ    = OP_WIDTH'(24);
    localparam logic [OP_WIDTH-1:0] OP_BNE    = OP_WIDTH'(25);
    localparam logic [OP_WIDTH-1:0] OP_BLT    = OP_WIDTH'(26);
    localparam logic [OP_WIDTH-1:0] OP_BGE    = OP_WIDTH'(27);
    localparam logic [OP_WIDTH-1:0] OP_BLTU   = OP_WIDTH'(28);
    localparam logic [OP_WIDTH-1:0] OP_BGEU   = OP_WIDTH'(29);
    localparam logic [OP_WIDTH-1:0] OP_MUL    = OP_WIDTH'(30);
    localparam logic [OP_WIDTH-1:0] OP_MULH   = OP_WIDTH'(31);
    localparam logic [OP_WIDTH-1:0] OP_MULHSU = OP_WIDTH'(32);
    localparam logic [OP_WIDTH-1:0] OP_MULHU  = OP_WIDTH'(33);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, HOLD} state_t;

    state_t              state;
    logic [CW-1:0]       cnt;
    logic [2*XLEN-1:0]   acc;
    logic [2*XLEN-1:0]   mcand;
    logic [XLEN-1:0]     mplier;
    logic                neg;
    logic                mul_high;

    logic                accept;
    logic                is_mul;
    logic                a_neg;
    logic                b_neg;
    logic [XLEN-1:0]     a_mag;
    logic [XLEN-1:0]     b_mag;
    logic [2*XLEN-1:0]   prod;
    logic [XLEN-1:0]     alu_data;
    logic                alu_jump;
    logic [XLEN-1:0]     alu_addr;

    assign in_ready = !rst && !flush && (state == IDLE || (state == HOLD && out_grant));
    assign accept   = in_valid && in_ready;
    assign is_mul   = (in_op == OP_MUL) || (in_op == OP_MULH) ||
                      (in_op == OP_MULHSU) || (in_op == OP_MULHU);

    // Multiply operand magnitudes and final signed product
    always_comb begin
        a_neg = ((in_op == OP_MULH) || (in_op == OP_MULHSU)) && in_a[XLEN-1];
        b_neg = (in_op == OP_MULH) && in_b[XLEN-1];
        a_mag = a_neg ? -in_a : in_a;
        b_mag = b_neg ? -in_b : in_b;
        prod  = neg ? -acc : acc;
    end

    // Single-cycle ALU, jump and branch result
    always_comb begin
        logic [XLEN-1:0] pc4;
        logic            taken;
        pc4      = in_pc + XLEN'(4);
        taken    = 1'b0;
        alu_data = '0;
        alu_jump = 1'b0;
        alu_addr = '0;
        case (in_op)
            OP_ADD:   alu_data = in_a + in_b;
            OP_SUB:   alu_data = in_a - in_b;
            OP_AND:   alu_data = in_a & in_b;
            OP_OR:    alu_data = in_a | in_b;
            OP_XOR:   alu_data = in_a ^ in_b;
            OP_ADDI:  alu_data = in_a + in_imm;
            OP_ANDI:  alu_data = in_a & in_imm;
            OP_ORI:   alu_data = in_a | in_imm;
            OP_XORI:  alu_data = in_a ^ in_imm;
            OP_SLL:   alu_data = in_a << in_b[SHW-1:0];
            OP_SRL:   alu_data = in_a >> in_b[SHW-1:0];
            OP_SRA:   alu_data = $signed(in_a) >>> in_b[SHW-1:0];
            OP_SLLI:  alu_data = in_a << in_imm[SHW-1:0];
            OP_SRLI:  alu_data = in_a >> in_imm[SHW-1:0];
            OP_SRAI:  alu_data = $signed(in_a) >>> in_imm[SHW-1:0];
            OP_SLT:   alu_data = XLEN'($signed(in_a) < $signed(in_b));
            OP_SLTI:  alu_data = XLEN'($signed(in_a) < $signed(in_imm));
            OP_SLTU:  alu_data = XLEN'(in_a < in_b);
            OP_SLTIU: alu_data = XLEN'(in_a < in_imm);
            OP_LUI:   alu_data = in_imm;
            OP_AUIPC: alu_data = in_pc + in_imm;
            OP_JAL:   alu_data = pc4;
            OP_JALR: begin
                alu_data = pc4;
                alu_jump = 1'b1;
                alu_addr = (in_a + in_imm) & ~XLEN'(1);
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (in_op)
                    OP_BEQ:  taken = (in_a == in_b);
                    OP_BNE:  taken = (in_a != in_b);
                    OP_BLT:  taken = ($signed(in_a) < $signed(in_b));
                    OP_BGE:  taken = ($signed(in_a) >= $signed(in_b));
                    OP_BLTU: taken = (in_a < in_b);
                    default: taken = (in_a >= in_b);
                endcase
                alu_data = XLEN'(taken);
                alu_jump = taken;
                alu_addr = taken ? (in_pc + in_imm) : pc4;
            end
            default: ;
        endcase
    end

    // Control FSM, multiply datapath and registered CDB outputs
    always_ff @(posedge clk) begin
        if (rst) begin
            state         <= IDLE;
            cnt           <= '0;
            acc           <= '0;
            mcand         <= '0;
            mplier        <= '0;
            neg           <= 1'b0;
            mul_high      <= 1'b0;
            out_valid     <= 1'b0;
            out_jump      <= 1'b0;
            out_data      <= '0;
            out_tag       <= '0;
            out_jump_addr <= '0;
        end else if (flush) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_jump  <= 1'b0;
        end else begin
            case (state)
                IDLE, HOLD: begin
                    if (accept) begin
                        out_tag <= in_tag;
                        if (is_mul) begin
                            acc       <= '0;
                            mcand     <= {{XLEN{1'b0}}, a_mag};
                            mplier    <= b_mag;
                            neg       <= a_neg ^ b_neg;
                            mul_high  <= (in_op != OP_MUL);
                            cnt       <= CW'(XLEN);
                            out_valid <= 1'b0;
                            out_jump  <= 1'b0;
                            state     <= MUL_BUSY;
                        end else begin
                            out_data      <= alu_data;
                            out_jump      <= alu_jump;
                            out_jump_addr <= alu_addr;
                            out_valid     <= 1'b1;
                            state         <= HOLD;
                        end
                    end else if (state == HOLD && out_grant) begin
                        out_valid <= 1'b0;
                        out_jump  <= 1'b0;
                        state     <= IDLE;
                    end
                end
                MUL_BUSY: begin
                    if (cnt != '0) begin
                        if (mplier[0]) begin
                            acc <= acc + mcand;
                        end
                        mcand  <= mcand << 1;
                        mplier <= mplier >> 1;
                        cnt    <= cnt - CW'(1);
                    end else begin
                        out_data      <= mul_high ? prod[2*XLEN-1:XLEN] : prod[XLEN-1:0];
                        out_jump      <= 1'b0;
                        out_jump_addr <= '0;
                        out_valid     <= 1'b1;
                        state         <= HOLD;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_exec_unit.sv
// tb_exec_unit: table-driven directed vectors, multi-cycle corner sequences and
// randomized ops checked against an arithmetic reference model.
module tb_exec_unit;

    localparam int XLEN = 32;

    localparam logic [5:0] OP_ADD = 6'd1, OP_SUB = 6'd2, OP_AND = 6'd3, OP_OR = 6'd4,
        OP_XOR = 6'd5, OP_ADDI = 6'd6, OP_ANDI = 6'd7, OP_ORI = 6'd8, OP_XORI = 6'd9,
        OP_SLL = 6'd10, OP_SRL = 6'd11, OP_SRA = 6'd12, OP_SLLI = 6'd13, OP_SRLI = 6'd14,
        OP_SRAI = 6'd15, OP_SLT = 6'd16, OP_SLTI = 6'd17, OP_SLTU = 6'd18, OP_SLTIU = 6'd19,
        OP_LUI = 6'd20, OP_AUIPC = 6'd21, OP_JAL = 6'd22, OP_JALR = 6'd23, OP_BEQ = 6'd24,
        OP_BNE = 6'd25, OP_BLT = 6'd26, OP_BGE = 6'd27, OP_BLTU = 6'd28, OP_BGEU = 6'd29,
        OP_MUL = 6'd30, OP_MULH = 6'd31, OP_MULHSU = 6'd32, OP_MULHU = 6'd33, OP_BAD = 6'd63;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        flush = 1'b0;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  in_op = '0;
    logic [31:0] in_a = '0, in_b = '0, in_imm = '0, in_pc = '0;
    logic [3:0]  in_tag = '0;
    logic        out_valid;
    logic        out_grant = 1'b0;
    logic [31:0] out_data;
    logic [3:0]  out_tag;
    logic        out_jump;
    logic [31:0] out_jump_addr;

    int n_cmp = 0;
    int n_bad = 0;

    exec_unit #(.XLEN(32), .ROB_WIDTH(4), .OP_WIDTH(6)) dut (
        .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid), .in_ready(in_ready),
        .in_op(in_op), .in_a(in_a), .in_b(in_b), .in_imm(in_imm), .in_pc(in_pc),
        .in_tag(in_tag), .out_valid(out_valid), .out_grant(out_grant),
        .out_data(out_data), .out_tag(out_tag), .out_jump(out_jump),
        .out_jump_addr(out_jump_addr)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic [5:0]  op;
        logic [31:0] a, b, imm, pc;
        logic [31:0] data;
        logic        jump;
        logic        chk;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic [5:0] op, logic [31:0] a, logic [31:0] b,
                                logic [31:0] imm, logic [31:0] pc, logic [31:0] data,
                                logic jump, logic chk, logic [31:0] addr);
        vec_t v;
        v.op = op; v.a = a; v.b = b; v.imm = imm; v.pc = pc;
        v.data = data; v.jump = jump; v.chk = chk; v.addr = addr;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit is_mul(logic [5:0] op);
        return op >= OP_MUL && op <= OP_MULHU;
    endfunction

    // Reference model: results straight from the ISA rules using wide arithmetic.
    task automatic model(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] imm, input logic [31:0] pc,
                         output logic [31:0] d, output logic j, output logic chk,
                         output logic [31:0] addr);
        logic [63:0] sa, sb, ua, ub, p;
        int signed   ia, ib, ii;
        bit          taken;
        ia = a; ib = b; ii = imm;
        sa = {{32{a[31]}}, a}; sb = {{32{b[31]}}, b};
        ua = {32'b0, a};       ub = {32'b0, b};
        d = 0; j = 0; chk = 0; addr = 0; taken = 0;
        case (op)
            OP_ADD:   d = a + b;
            OP_SUB:   d = a - b;
            OP_AND:   d = a & b;
            OP_OR:    d = a | b;
            OP_XOR:   d = a ^ b;
            OP_ADDI:  d = a + imm;
            OP_ANDI:  d = a & imm;
            OP_ORI:   d = a | imm;
            OP_XORI:  d = a ^ imm;
            OP_SLL:   d = a << (b % 32);
            OP_SRL:   d = a >> (b % 32);
            OP_SRA:   d = ia >>> (b % 32);
            OP_SLLI:  d = a << (imm % 32);
            OP_SRLI:  d = a >> (imm % 32);
            OP_SRAI:  d = ia >>> (imm % 32);
            OP_SLT:   d = (ia < ib) ? 1 : 0;
            OP_SLTI:  d = (ia < ii) ? 1 : 0;
            OP_SLTU:  d = (a < b) ? 1 : 0;
            OP_SLTIU: d = (a < imm) ? 1 : 0;
            OP_LUI:   d = imm;
            OP_AUIPC: d = pc + imm;
            OP_JAL:   d = pc + 4;
            OP_JALR: begin
                d = pc + 4; j = 1; chk = 1; addr = (a + imm) & 32'hFFFF_FFFE;
            end
            OP_BEQ, OP_BNE, OP_BLT, OP_BGE, OP_BLTU, OP_BGEU: begin
                case (op)
                    OP_BEQ:  taken = (a == b);
                    OP_BNE:  taken = (a != b);
                    OP_BLT:  taken = (ia < ib);
                    OP_BGE:  taken = !(ia < ib);
                    OP_BLTU: taken = (a < b);
                    default: taken = !(a < b);
                endcase
                d = taken ? 1 : 0; j = taken; chk = 1;
                addr = taken ? pc + imm : pc + 4;
            end
            OP_MUL:    begin p = ua * ub; d = p[31:0];  end
            OP_MULHU:  begin p = ua * ub; d = p[63:32]; end
            OP_MULH:   begin p = sa * sb; d = p[63:32]; end
            OP_MULHSU: begin p = sa * ub; d = p[63:32]; end
            default: ;
        endcase
    endtask

    // Issue one op with out_grant high, wait for its result, check it, then
    // optionally withhold the grant for 'hold' cycles checking stability.
    task automatic run_op(input logic [5:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] imm, input logic [31:0] pc, input logic [3:0] tag,
                          input logic [31:0] ed, input logic ej, input logic chk,
                          input logic [31:0] ea, input int hold);
        int cyc;
        int busy_ready;
        in_op = op; in_a = a; in_b = b; in_imm = imm; in_pc = pc; in_tag = tag;
        in_valid = 1'b1;
        out_grant = 1'b1;
        #1;
        check("issue_ready", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (is_mul(op)) begin
            cyc = 0;
            busy_ready = 0;
            while (!out_valid && cyc < 100) begin
                if (in_ready) busy_ready++;
                @(posedge clk); #1;
                cyc++;
            end
            check("mul_latency", 32'(cyc), 32'(XLEN + 1));
            check("mul_busy_ready", 32'(busy_ready), 32'd0);
        end
        for (int k = 0; k <= hold; k++) begin
            check("out_valid", 32'(out_valid), 32'd1);
            check("out_data", out_data, ed);
            check("out_tag", 32'(out_tag), 32'(tag));
            check("out_jump", 32'(out_jump), 32'(ej));
            if (chk) check("out_jump_addr", out_jump_addr, ea);
            if (k < hold) begin
                out_grant = 1'b0;
                @(posedge clk); #1;
            end
        end
    endtask

    function automatic logic [31:0] rnd_val();
        case ($urandom_range(0, 5))
            0: return 32'h0;
            1: return 32'h1;
            2: return 32'hFFFF_FFFF;
            3: return 32'h8000_0000;
            4: return 32'h7FFF_FFFF;
            default: return $urandom;
        endcase
    endfunction

    initial begin
        logic [5:0]  op;
        logic [31:0] a, b, imm, pc, d, addr;
        logic        j, chk;
        int          vcnt;

        vecs.push_back(mk(OP_SUB,   32'd3, 32'd5, 0, 0, 32'hFFFF_FFFE, 0, 0, 0));
        vecs.push_back(mk(OP_SRA,   32'h8000_0000, 32'h21, 0, 0, 32'hC000_0000, 0, 0, 0));
        vecs.push_back(mk(OP_SLTU,  32'd1, 32'hFFFF_FFFF, 0, 0, 32'd1, 0, 0, 0));
        vecs.push_back(mk(OP_BNE,   32'd1, 32'd2, 32'h20, 32'h100, 32'd1, 1, 1, 32'h120));
        vecs.push_back(mk(OP_BEQ,   32'd1, 32'd2, 32'h20, 32'h100, 32'd0, 0, 1, 32'h104));
        vecs.push_back(mk(OP_JALR,  32'h1001, 0, 32'd2, 32'h40, 32'h44, 1, 1, 32'h1002));
        vecs.push_back(mk(OP_SLT,   32'hFFFF_FFFF, 32'd1, 0, 0, 32'd1, 0, 0, 0));
        vecs.push_back(mk(OP_SLTIU, 32'd5, 0, 32'hFFFF_FFFF, 0, 32'd1, 0, 0, 0));
        vecs.push_back(mk(OP_LUI,   0, 0, 32'hABCD_E000, 0, 32'hABCD_E000, 0, 0, 0));
        vecs.push_back(mk(OP_AUIPC, 0, 0, 32'h2000, 32'h1000, 32'h3000, 0, 0, 0));
        vecs.push_back(mk(OP_JAL,   0, 0, 32'h80, 32'h200, 32'h204, 0, 0, 0));
        vecs.push_back(mk(OP_BLT,   32'hFFFF_FFFE, 32'd1, 32'hFFFF_FFF0, 32'h80, 32'd1, 1, 1, 32'h70));
        vecs.push_back(mk(OP_BGEU,  32'd1, 32'hFFFF_FFFF, 32'h40, 32'h300, 32'd0, 0, 1, 32'h304));
        vecs.push_back(mk(OP_SLLI,  32'd1, 0, 32'd31, 0, 32'h8000_0000, 0, 0, 0));
        vecs.push_back(mk(OP_XORI,  32'h0000_F0F0, 0, 32'hFFFF_FFFF, 0, 32'hFFFF_0F0F, 0, 0, 0));
        vecs.push_back(mk(OP_BAD,   32'd9, 32'd9, 32'd9, 32'h10, 32'd0, 0, 0, 0));
        vecs.push_back(mk(OP_MULH,  32'hFFFF_FFFD, 32'd7, 0, 0, 32'hFFFF_FFFF, 0, 0, 0));
        vecs.push_back(mk(OP_MUL,   32'hFFFF_FFFD, 32'd7, 0, 0, 32'hFFFF_FFEB, 0, 0, 0));
        vecs.push_back(mk(OP_MULHU, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'd1, 0, 0, 0));
        vecs.push_back(mk(OP_MULHSU, 32'hFFFF_FFFF, 32'd2, 0, 0, 32'hFFFF_FFFF, 0, 0, 0));
        vecs.push_back(mk(OP_MULH,  32'h8000_0000, 32'h8000_0000, 0, 0, 32'h4000_0000, 0, 0, 0));

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_ready", 32'(in_ready), 32'd0);
        check("rst_valid", 32'(out_valid), 32'd0);
        check("rst_data", out_data, 32'd0);
        check("rst_tag", 32'(out_tag), 32'd0);
        check("rst_jump", 32'(out_jump), 32'd0);
        check("rst_addr", out_jump_addr, 32'd0);
        rst = 1'b0;

        // ADD, then result retires the following cycle
        run_op(OP_ADD, 32'd5, 32'd7, 0, 0, 4'd3, 32'd12, 1'b0, 1'b0, 0, 0);
        out_grant = 1'b1;
        @(posedge clk); #1;
        check("add_retired", 32'(out_valid), 32'd0);

        // Directed table, back-to-back with grant held high
        vcnt = 0;
        foreach (vecs[i]) begin
            run_op(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].imm, vecs[i].pc, 4'(i),
                   vecs[i].data, vecs[i].jump, vecs[i].chk, vecs[i].addr, 0);
            vcnt++;
        end

        // Hold for 5 cycles, then flush together with grant and a new request
        run_op(OP_ADD, 32'd100, 32'd23, 0, 0, 4'd9, 32'd123, 1'b0, 1'b0, 0, 5);
        flush = 1'b1; out_grant = 1'b1; in_valid = 1'b1;
        in_op = OP_ADD; in_a = 32'd1; in_b = 32'd1; in_tag = 4'd4;
        #1;
        check("flush_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        check("flush_valid", 32'(out_valid), 32'd0);
        check("flush_jump", 32'(out_jump), 32'd0);
        @(posedge clk); #1;
        check("flush_dropped", 32'(out_valid), 32'd0);
        check("flush_idle_ready", 32'(in_ready), 32'd1);

        // Flush during MUL_BUSY: no result ever appears
        in_op = OP_MUL; in_a = 32'd6; in_b = 32'd7; in_tag = 4'd5; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        vcnt = 0;
        for (int k = 0; k < XLEN + 5; k++) begin
            if (out_valid) vcnt++;
            @(posedge clk); #1;
        end
        check("mul_flush_novalid", 32'(vcnt), 32'd0);
        check("mul_flush_ready", 32'(in_ready), 32'd1);

        // Reset during MUL_BUSY: outputs to reset values, op lost
        in_op = OP_MULHU; in_a = 32'hFFFF_FFFF; in_b = 32'd3; in_tag = 4'd11; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        check("rst_busy_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        check("rst_busy_tag", 32'(out_tag), 32'd0);
        check("rst_busy_valid", 32'(out_valid), 32'd0);
        rst = 1'b0;
        vcnt = 0;
        for (int k = 0; k < XLEN + 5; k++) begin
            if (out_valid) vcnt++;
            @(posedge clk); #1;
        end
        check("rst_busy_lost", 32'(vcnt), 32'd0);

        // Randomized ops against the reference model
        for (int i = 0; i < 150; i++) begin
            int sel;
            sel = $urandom_range(0, 33);
            op  = (sel == 33) ? OP_BAD : 6'(sel + 1);
            a   = rnd_val();
            b   = rnd_val();
            imm = rnd_val();
            pc  = $urandom & 32'hFFFF_FFFC;
            model(op, a, b, imm, pc, d, j, chk, addr);
            run_op(op, a, b, imm, pc, 4'($urandom_range(0, 15)), d, j, chk, addr,
                   $urandom_range(0, 2));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
